uart_packet_rx: RTL and testbench
=================================

Name: uart_packet_rx

Overview:
- Receive-side packet assembler: the counterpart of the packetising UART transmitter.
- Consumes the byte stream from uart_rx (one-cycle m_valid pulses, no backpressure).
- Packs PACKET_SIZE consecutive words into one wide word and presents it on a valid/ready master port to the vector core.
- Discards partial packets after an inter-byte gap and flags words dropped while the output is blocked.

Parameters:
- BITS_PER_WORD, 8, width of each received word.
- PACKET_SIZE, 13, words per packet (>=2).
- TIMEOUT_CYCLES, 200000, idle clocks inside a packet before the partial packet is discarded (20 bit-times at 10000 clocks per bit).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- s_valid  input  1  word strobe from uart_rx; one-cycle pulse per word.
- s_data  input  BITS_PER_WORD  received word; valid only when s_valid=1.
- m_valid  output  1  packet available on m_data.
- m_ready  input  1  downstream accepts the packet.
- m_data  output  PACKET_SIZE*BITS_PER_WORD  packet; first received word in bits [BITS_PER_WORD-1:0], last word in the MSBs.
- word_cnt  output  clog2(PACKET_SIZE+1)  words held in the assembly register.
- err_timeout  output  1  one-cycle pulse when a partial packet is discarded.
- err_overrun  output  1  one-cycle pulse when an incoming word is dropped.

Behaviour:
- Reset (rst=1 at a clk edge), takes priority over all events:
  - state=IDLE, word_cnt=0, idle counter=0.
  - m_valid=0, m_data=0, err_timeout=0, err_overrun=0.
  - A mid-packet reset discards the partial packet and any held output without pulses.
- Output slot free (slot_free) = !m_valid || m_ready. A transfer occurs when m_valid && m_ready.
- m_valid and m_data hold stable until transfer. After transfer m_valid drops next cycle unless a new packet loads in the same cycle.
- States:
  - IDLE (word_cnt=0):
    - On s_valid: word 0 goes into the assembly register, word_cnt=1, go to COLLECT.
  - COLLECT (0<word_cnt<PACKET_SIZE):
    - On s_valid: store word at index word_cnt and clear the idle counter.
      - If word_cnt==PACKET_SIZE-1 and slot_free: load m_data with the full packet (including this word), m_valid=1 next cycle, word_cnt=0, go to IDLE.
      - If word_cnt==PACKET_SIZE-1 and not slot_free: word_cnt=PACKET_SIZE, go to FULL.
      - Otherwise: word_cnt+1.
    - No s_valid: idle counter+1. When it reaches TIMEOUT_CYCLES-1: discard, word_cnt=0, pulse err_timeout for one cycle, go to IDLE.
  - FULL (word_cnt=PACKET_SIZE):
    - When slot_free: load m_data from assembly, m_valid=1, word_cnt=0, go to IDLE.
    - If s_valid arrives in the same cycle as that load: the word is accepted as word 0 (word_cnt=1, go to COLLECT). No drop.
    - If s_valid arrives while not slot_free: drop the word, pulse err_overrun. State and data unchanged.
- No timeout in IDLE or FULL.
- Latency: m_valid asserts on the clock after the last word's s_valid when the slot is free; m_data is registered.
- At most one packet is buffered in FULL plus one presented on m_data. Total storage is 2*PACKET_SIZE words.
- Counters are sized to avoid wrap. The idle counter saturates by construction, since it is cleared on timeout.

Test Plan:
- Basic packet, m_ready=1, PACKET_SIZE=13: send 13 words 0x01..0x0D, spaced 50 clocks -> m_valid high for exactly 1 cycle starting the clock after the 13th pulse, m_data[7:0]=0x01, m_data[103:96]=0x0D, word_cnt returns 0.
- Backpressure, m_ready=0: send 26 words 0x00..0x19 -> first packet held stable with m_valid=1. Second packet completes into FULL (word_cnt=13). Raise m_ready for one cycle -> packet 1 transfers; next cycle m_valid=1 with packet 2 (m_data[7:0]=0x0D).
- Overrun: in FULL with m_ready=0, send 0xAA -> err_overrun pulses for 1 cycle, 0xAA is absent from every later packet, word_cnt stays 13.
- Timeout, TIMEOUT_CYCLES=50: send 5 words then idle 60 clocks -> err_timeout pulses exactly 50 clocks after the 5th word, word_cnt=0. A following 13-word packet arrives intact with no leftover words.
- Simultaneous load and word: in FULL, assert m_ready in the same cycle as s_valid=0x55 -> held packet transfers, 0x55 becomes word 0 (word_cnt=1), no err_overrun.
- Reset mid-packet: after 7 words assert rst for 1 cycle -> m_valid=0, word_cnt=0, no error pulses. The next 13 words form a correct packet.

Source files
------------

// File: rtl/uart_packet_rx.sv
// Receive-side packet assembler: packs PACKET_SIZE words from uart_rx into one wide word
// and presents it on a valid/ready port, with inter-byte timeout and overrun flags.
module uart_packet_rx #(
    parameter int BITS_PER_WORD  = 8,
    parameter int PACKET_SIZE    = 13,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    input  logic [BITS_PER_WORD-1:0]              s_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [PACKET_SIZE*BITS_PER_WORD-1:0]  m_data,
    output logic [$clog2(PACKET_SIZE+1)-1:0]      word_cnt,
    output logic                                  err_timeout,
    output logic                                  err_overrun
);

    localparam int CNT_W = $clog2(PACKET_SIZE + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PKT_W = PACKET_SIZE * BITS_PER_WORD;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACKET_SIZE);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_cnt_d;
    logic [TMO_W-1:0]   idle_q, idle_d;
    logic [PKT_W-1:0]   asm_q, asm_d, asm_wr;
    logic [CNT_W-1:0]   wr_idx;
    logic               slot_free;
    logic               load;
    logic               load_from_wr;
    logic               m_valid_d;
    logic [PKT_W-1:0]   m_data_d;
    logic               err_timeout_d;
    logic               err_overrun_d;

    assign slot_free = !m_valid || m_ready;

    // Assembly register with the incoming word merged at wr_idx
    always_comb begin
        asm_wr = asm_q;
        for (int i = 0; i < PACKET_SIZE; i++) begin
            if (wr_idx == CNT_W'(i)) begin
                asm_wr[i*BITS_PER_WORD +: BITS_PER_WORD] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_cnt    <= '0;
            idle_q      <= '0;
            asm_q       <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt    <= word_cnt_d;
            idle_q      <= idle_d;
            asm_q       <= asm_d;
            m_valid     <= m_valid_d;
            m_data      <= m_data_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt;
        idle_d        = idle_q;
        asm_d         = asm_q;
        wr_idx        = '0;
        load          = 1'b0;
        load_from_wr  = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    asm_d      = asm_wr;
                    word_cnt_d = CNT_W'(1);
                    idle_d     = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                wr_idx = word_cnt;
                if (s_valid) begin
                    asm_d  = asm_wr;
                    idle_d = '0;
                    if (word_cnt == LAST_IDX) begin
                        if (slot_free) begin
                            load         = 1'b1;
                            load_from_wr = 1'b1;
                            word_cnt_d   = '0;
                            state_d      = IDLE;
                        end else begin
                            word_cnt_d = FULL_CNT;
                            state_d    = FULL;
                        end
                    end else begin
                        word_cnt_d = word_cnt + CNT_W'(1);
                    end
                end else if (idle_q == TMO_LAST) begin
                    word_cnt_d    = '0;
                    idle_d        = '0;
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    idle_d = idle_q + TMO_W'(1);
                end
            end
            FULL: begin
                // A word arriving with the load starts the next packet instead of being dropped
                if (slot_free) begin
                    load       = 1'b1;
                    word_cnt_d = '0;
                    state_d    = IDLE;
                    if (s_valid) begin
                        asm_d      = asm_wr;
                        word_cnt_d = CNT_W'(1);
                        idle_d     = '0;
                        state_d    = COLLECT;
                    end
                end else if (s_valid) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                word_cnt_d = '0;
                idle_d     = '0;
            end
        endcase
    end

    always_comb begin
        m_valid_d = m_valid && !m_ready;
        m_data_d  = m_data;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = load_from_wr ? asm_wr : asm_q;
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: a queue-based packet model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_uart_packet_rx;

    localparam int W   = 8;
    localparam int PS  = 13;
    localparam int TMO = 50;
    localparam int PW  = PS * W;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid;
    logic [W-1:0]   s_data;
    logic           m_valid;
    logic           m_ready;
    logic [PW-1:0]  m_data;
    logic [3:0]     word_cnt;
    logic           err_timeout;
    logic           err_overrun;

    int vectors     = 0;
    int miscompares = 0;

    uart_packet_rx #(
        .BITS_PER_WORD (W),
        .PACKET_SIZE   (PS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .word_cnt   (word_cnt),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: words of the packet being assembled (13 entries means one is waiting)
    logic [W-1:0]   cur[$];
    int             idle_cnt;
    logic           exp_mv;
    logic [PW-1:0]  exp_md;
    logic           exp_to;
    logic           exp_ov;
    bit             live = 0;

    function automatic logic [PW-1:0] packCur();
        logic [PW-1:0] p = '0;
        for (int i = 0; i < cur.size(); i++) p[i*W +: W] = cur[i];
        return p;
    endfunction

    always @(posedge clk) begin : model
        bit free;
        exp_to = 1'b0;
        exp_ov = 1'b0;
        if (rst) begin
            cur.delete();
            idle_cnt = 0;
            exp_mv   = 1'b0;
            exp_md   = '0;
            live     = 1;
        end else if (live) begin
            free = !exp_mv || m_ready;
            if (exp_mv && m_ready) exp_mv = 1'b0;
            if (cur.size() == PS) begin
                if (free) begin
                    exp_md = packCur();
                    exp_mv = 1'b1;
                    cur.delete();
                    idle_cnt = 0;
                    if (s_valid) cur.push_back(s_data);
                end else if (s_valid) begin
                    exp_ov = 1'b1;
                end
            end else if (s_valid) begin
                cur.push_back(s_data);
                idle_cnt = 0;
                if (cur.size() == PS && free) begin
                    exp_md = packCur();
                    exp_mv = 1'b1;
                    cur.delete();
                end
            end else if (cur.size() > 0) begin
                if (idle_cnt == TMO - 1) begin
                    cur.delete();
                    idle_cnt = 0;
                    exp_to   = 1'b1;
                end else begin
                    idle_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            checkOutput("m_valid", PW'(m_valid), PW'(exp_mv));
            if (exp_mv) checkOutput("m_data", m_data, exp_md);
            checkOutput("word_cnt", PW'(word_cnt), PW'(cur.size()));
            checkOutput("err_timeout", PW'(err_timeout), PW'(exp_to));
            checkOutput("err_overrun", PW'(err_overrun), PW'(exp_ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] data, input int gap);
        s_valid = 1'b1;
        s_data  = data;
        tick();
        s_valid = 1'b0;
        s_data  = '0;
        repeat (gap) tick();
    endtask

    initial begin
        int to_at;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) tick();
        checkOutput("reset_m_valid", PW'(m_valid), PW'(1'b0));
        checkOutput("reset_m_data", m_data, '0);
        checkOutput("reset_word_cnt", PW'(word_cnt), PW'(4'd0));
        rst = 1'b0;

        // Basic packet with 49 idle clocks between words, one short of the timeout
        for (int i = 1; i <= PS; i++) applyStimulus(W'(i), (i == PS) ? 0 : 49);
        checkOutput("basic_valid", PW'(m_valid), PW'(1'b1));
        checkOutput("basic_first", PW'(m_data[7:0]), PW'(8'h01));
        checkOutput("basic_last", PW'(m_data[103:96]), PW'(8'h0D));
        checkOutput("basic_cnt", PW'(word_cnt), PW'(4'd0));
        tick();
        checkOutput("basic_drop", PW'(m_valid), PW'(1'b0));

        // Backpressure: two packets, one presented and one waiting
        m_ready = 1'b0;
        for (int i = 0; i < 2*PS; i++) applyStimulus(W'(i), 1);
        checkOutput("bp_valid", PW'(m_valid), PW'(1'b1));
        checkOutput("bp_first", PW'(m_data[7:0]), PW'(8'h00));
        checkOutput("bp_last", PW'(m_data[103:96]), PW'(8'h0C));
        checkOutput("bp_full_cnt", PW'(word_cnt), PW'(4'd13));

        applyStimulus(8'hAA, 0);
        checkOutput("ovr_pulse", PW'(err_overrun), PW'(1'b1));
        checkOutput("ovr_cnt", PW'(word_cnt), PW'(4'd13));
        tick();
        checkOutput("ovr_end", PW'(err_overrun), PW'(1'b0));

        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("bp2_valid", PW'(m_valid), PW'(1'b1));
        checkOutput("bp2_first", PW'(m_data[7:0]), PW'(8'h0D));
        checkOutput("bp2_last", PW'(m_data[103:96]), PW'(8'h19));
        checkOutput("bp2_cnt", PW'(word_cnt), PW'(4'd0));

        // Simultaneous load and new word while a packet waits
        for (int i = 0; i < PS; i++) applyStimulus(W'(8'h30 + i), 0);
        checkOutput("sim_full", PW'(word_cnt), PW'(4'd13));
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        tick();
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        checkOutput("sim_valid", PW'(m_valid), PW'(1'b1));
        checkOutput("sim_first", PW'(m_data[7:0]), PW'(8'h30));
        checkOutput("sim_cnt", PW'(word_cnt), PW'(4'd1));
        checkOutput("sim_no_ovr", PW'(err_overrun), PW'(1'b0));
        m_ready = 1'b1;
        tick();
        checkOutput("sim_drain", PW'(m_valid), PW'(1'b0));
        repeat (60) tick();

        // Timeout after 5 words
        for (int i = 0; i < 5; i++) applyStimulus(W'(8'h60 + i), 0);
        to_at = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (err_timeout && to_at == 0) to_at = k;
        end
        checkOutput("tmo_delay", PW'(to_at), PW'(50));
        checkOutput("tmo_cnt", PW'(word_cnt), PW'(4'd0));
        for (int i = 0; i < PS; i++) applyStimulus(W'(8'h70 + i), 0);
        checkOutput("tmo_pkt_valid", PW'(m_valid), PW'(1'b1));
        checkOutput("tmo_pkt_first", PW'(m_data[7:0]), PW'(8'h70));
        checkOutput("tmo_pkt_last", PW'(m_data[103:96]), PW'(8'h7C));
        tick();

        // Reset in the middle of a packet
        for (int i = 0; i < 7; i++) applyStimulus(W'(8'h90 + i), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_valid", PW'(m_valid), PW'(1'b0));
        checkOutput("rst_cnt", PW'(word_cnt), PW'(4'd0));
        checkOutput("rst_to", PW'(err_timeout), PW'(1'b0));
        checkOutput("rst_ovr", PW'(err_overrun), PW'(1'b0));
        for (int i = 0; i < PS; i++) applyStimulus(W'(8'hA0 + i), 0);
        checkOutput("rst_pkt_first", PW'(m_data[7:0]), PW'(8'hA0));
        checkOutput("rst_pkt_last", PW'(m_data[103:96]), PW'(8'hAC));
        checkOutput("rst_pkt_cnt", PW'(word_cnt), PW'(4'd0));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
